// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA sprite pipeline.
//   CntW      - width of the hcount/vcount timing counters
//   ColorW    - width of an RGB444 pixel
//   PosW      - width of the requested sprite position
//   CmpW      - width of the hit comparisons (one bit of headroom so a sprite clips and does not wrap)
//   PipeDepth - latency in pclk from timing input to timing output
package vga_pkg;

    localparam int unsigned CntW      = 11;
    localparam int unsigned ColorW    = 12;
    localparam int unsigned PosW      = 12;
    localparam int unsigned CmpW      = 13;
    localparam int unsigned PipeDepth = 3;

    // One beat of the timing bus plus its background colour.
    typedef struct packed {
        logic [CntW-1:0]   hcount;
        logic [CntW-1:0]   vcount;
        logic              hsync;
        logic              vsync;
        logic              hblnk;
        logic              vblnk;
        logic [ColorW-1:0] rgb;
    } vga_bus_t;

    // Address field width: clog2, but never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/draw_sprite_if.sv
// VGA timing bus: counters, sync/blank strobes and pixel colour.
//   master - drives the bus (producer side)
//   slave  - receives the bus (consumer side)
interface draw_sprite_if;
    import vga_pkg::*;

    logic [CntW-1:0]   hcount;
    logic [CntW-1:0]   vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [ColorW-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/sprite_addr_gen.sv
// Sprite hit detection and ROM address generation.
//   pclk, rst          - pixel clock, async active-low reset
//   hcount, vcount     - current beam position (stage 0)
//   hblnk, vblnk       - blanking strobes; no hit while blanking
//   xa, ya, en, flip, s2 - frame-latched sprite position and mode
//   hit                - combinational: beam is inside the visible sprite
//   pixel_addr         - registered {row, col}; holds when hit is low
module sprite_addr_gen
    import vga_pkg::*;
#(
    parameter int unsigned SPR_W = 48,
    parameter int unsigned SPR_H = 64,
    parameter int unsigned XW    = 6,
    parameter int unsigned YW    = 6,
    parameter int unsigned AW    = 12
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic [CntW-1:0] hcount,
    input  logic [CntW-1:0] vcount,
    input  logic            hblnk,
    input  logic            vblnk,
    input  logic [PosW-1:0] xa,
    input  logic [PosW-1:0] ya,
    input  logic            en,
    input  logic            flip,
    input  logic            s2,
    output logic            hit,
    output logic [AW-1:0]   pixel_addr
);

    localparam int unsigned DxW = XW + 1;
    localparam int unsigned DyW = YW + 1;

    logic [CmpW-1:0] hc, vc, xs, ys, ew, eh;
    logic [DxW-1:0]  dx;
    logic [DyW-1:0]  dy;
    logic [XW-1:0]   col_off;
    logic [XW-1:0]   col;
    logic [YW-1:0]   row;

    assign hc = CmpW'(hcount);
    assign vc = CmpW'(vcount);
    assign xs = CmpW'(xa);
    assign ys = CmpW'(ya);
    assign ew = s2 ? CmpW'(2 * SPR_W) : CmpW'(SPR_W);
    assign eh = s2 ? CmpW'(2 * SPR_H) : CmpW'(SPR_H);

    assign hit = en && !hblnk && !vblnk &&
                 (hc >= xs) && (hc < xs + ew) &&
                 (vc >= ys) && (vc < ys + eh);

    // Inside a hit the offset is below 2*SPR_W, so one extra bit over the field suffices.
    assign dx = DxW'(hc - xs);
    assign dy = DyW'(vc - ys);

    assign col_off = s2 ? dx[XW:1] : dx[XW-1:0];
    assign row     = s2 ? dy[YW:1] : dy[YW-1:0];
    assign col     = flip ? (XW'(SPR_W - 1) - col_off) : col_off;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            pixel_addr <= '0;
        end else if (hit) begin
            pixel_addr <= {row, col};
        end
    end

endmodule

// File: rtl/draw_sprite.sv
// Overlays a ROM sprite on a VGA timing stream.
//   pclk, rst        - pixel clock, async active-low reset
//   src              - incoming timing bus and background colour
//   dst              - timing bus delayed by PipeDepth, with the sprite composed in
//   xpos, ypos       - requested top-left corner, taken at the vblnk rising edge
//   enable, hflip, scale2 - sprite mode, taken at the vblnk rising edge
//   rgb_pixel        - ROM data for pixel_addr, valid one pclk after the address
//   pixel_addr       - ROM address {row, col}
module draw_sprite
    import vga_pkg::*;
#(
    parameter int unsigned       SPR_W     = 48,
    parameter int unsigned       SPR_H     = 64,
    parameter bit                KEY_EN    = 1'b1,
    parameter logic [ColorW-1:0] KEY_COLOR = 12'h000,
    localparam int unsigned      XW        = clog2_min1(SPR_W),
    localparam int unsigned      YW        = clog2_min1(SPR_H),
    localparam int unsigned      AW        = XW + YW
) (
    input  logic              pclk,
    input  logic              rst,
    draw_sprite_if.slave      src,
    draw_sprite_if.master     dst,
    input  logic [PosW-1:0]   xpos,
    input  logic [PosW-1:0]   ypos,
    input  logic              enable,
    input  logic              hflip,
    input  logic              scale2,
    input  logic [ColorW-1:0] rgb_pixel,
    output logic [AW-1:0]     pixel_addr
);

    localparam int unsigned StageN = PipeDepth - 1;

    vga_bus_t          bus_in;
    vga_bus_t          bus_q [StageN];
    logic              hit_q [StageN];
    logic [ColorW-1:0] pix_q;
    vga_bus_t          out_q, out_d;

    logic              vblnk_prev_q;
    logic              frame_latch;
    logic [PosW-1:0]   xa_q, ya_q;
    logic              en_q, flip_q, s2_q;
    logic              hit;
    logic              draw;

    always_comb begin
        bus_in.hcount = src.hcount;
        bus_in.vcount = src.vcount;
        bus_in.hsync  = src.hsync;
        bus_in.vsync  = src.vsync;
        bus_in.hblnk  = src.hblnk;
        bus_in.vblnk  = src.vblnk;
        bus_in.rgb    = src.rgb;
    end

    // Mode is only taken at the start of vertical blank so a frame is never torn.
    assign frame_latch = src.vblnk && !vblnk_prev_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vblnk_prev_q <= 1'b0;
            xa_q         <= '0;
            ya_q         <= '0;
            en_q         <= 1'b0;
            flip_q       <= 1'b0;
            s2_q         <= 1'b0;
        end else begin
            vblnk_prev_q <= src.vblnk;
            if (frame_latch) begin
                xa_q   <= xpos;
                ya_q   <= ypos;
                en_q   <= enable;
                flip_q <= hflip;
                s2_q   <= scale2;
            end
        end
    end

    sprite_addr_gen #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .XW    (XW),
        .YW    (YW),
        .AW    (AW)
    ) u_addr_gen (
        .pclk       (pclk),
        .rst        (rst),
        .hcount     (src.hcount),
        .vcount     (src.vcount),
        .hblnk      (src.hblnk),
        .vblnk      (src.vblnk),
        .xa         (xa_q),
        .ya         (ya_q),
        .en         (en_q),
        .flip       (flip_q),
        .s2         (s2_q),
        .hit        (hit),
        .pixel_addr (pixel_addr)
    );

    // pix_q captures the ROM word at stage 2, lining it up with bus_q[StageN-1].
    assign draw = hit_q[StageN-1] && !(KEY_EN && (pix_q == KEY_COLOR));

    always_comb begin
        out_d = bus_q[StageN-1];
        if (draw) begin
            out_d.rgb = pix_q;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < StageN; i++) begin
                bus_q[i] <= '0;
                hit_q[i] <= 1'b0;
            end
            pix_q <= '0;
            out_q <= '0;
        end else begin
            bus_q[0] <= bus_in;
            hit_q[0] <= hit;
            for (int i = 1; i < StageN; i++) begin
                bus_q[i] <= bus_q[i-1];
                hit_q[i] <= hit_q[i-1];
            end
            pix_q <= rgb_pixel;
            out_q <= out_d;
        end
    end

    assign dst.hcount = out_q.hcount;
    assign dst.vcount = out_q.vcount;
    assign dst.hsync  = out_q.hsync;
    assign dst.vsync  = out_q.vsync;
    assign dst.hblnk  = out_q.hblnk;
    assign dst.vblnk  = out_q.vblnk;
    assign dst.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_sprite.sv
// Scoreboard bench for draw_sprite: two instances (colour key on and off) share one
// timing stream; expected outputs are queued at drive time and compared 3 cycles later.
module tb_draw_sprite;
    import vga_pkg::*;

    localparam int SprW = 48;
    localparam int SprH = 64;
    localparam int Lat  = 3;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    always #5 pclk = ~pclk;

    draw_sprite_if vin ();
    draw_sprite_if vout0 ();
    draw_sprite_if vout1 ();

    logic [11:0] xpos = '0, ypos = '0;
    logic        enable = 1'b0, hflip = 1'b0, scale2 = 1'b0;
    logic [11:0] addr0, addr1, pix0, pix1;
    logic        rom_zero = 1'b0;

    // Combinational ROM model; data is never zero unless rom_zero is set.
    assign pix0 = rom_zero ? 12'h000 : {1'b1, addr0[10:0]};
    assign pix1 = rom_zero ? 12'h000 : {1'b1, addr1[10:0]};

    draw_sprite u_dut_key (
        .pclk(pclk), .rst(rst), .src(vin), .dst(vout0),
        .xpos(xpos), .ypos(ypos), .enable(enable), .hflip(hflip), .scale2(scale2),
        .rgb_pixel(pix0), .pixel_addr(addr0)
    );

    draw_sprite #(.KEY_EN(1'b0)) u_dut_nokey (
        .pclk(pclk), .rst(rst), .src(vin), .dst(vout1),
        .xpos(xpos), .ypos(ypos), .enable(enable), .hflip(hflip), .scale2(scale2),
        .rgb_pixel(pix1), .pixel_addr(addr1)
    );

    typedef struct {
        int          due;
        logic [11:0] rgb_key;
        logic [11:0] rgb_nokey;
        logic [25:0] tim;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Reference state: what the bench believes the active registers hold.
    int m_x = 0, m_y = 0;
    bit m_en = 0, m_flip = 0, m_s2 = 0, m_prev = 0;
    int m_addr = 0;
    int spot_pend = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (rst && sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq("rgb_key", 64'(vout0.rgb), 64'(e.rgb_key));
            check_eq("rgb_nokey", 64'(vout1.rgb), 64'(e.rgb_nokey));
            check_eq("timing", 64'({vout0.hcount, vout0.vcount, vout0.hsync, vout0.vsync,
                                    vout0.hblnk, vout0.vblnk}), 64'(e.tim));
        end
    end

    task automatic step(input int h, input int v, input bit hb, input bit vb, input int spot);
        logic [10:0] hh, vv;
        logic [11:0] rgbv, a12, pix;
        int ew, eh, dx, dy, col, addr;
        bit hit;
        exp_t x;
        @(posedge pclk);
        #1;
        check_eq("addr_key", 64'(addr0), 64'(m_addr));
        check_eq("addr_nokey", 64'(addr1), 64'(m_addr));
        if (spot_pend >= 0) check_eq("addr_spot", 64'(addr0), 64'(spot_pend));
        spot_pend = spot;
        hh = 11'(h);
        vv = 11'(v);
        rgbv = {1'b0, 11'(h * 3 + v + 1)};
        vin.hcount = hh;
        vin.vcount = vv;
        vin.hsync  = hh[4];
        vin.vsync  = vv[0];
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgbv;
        ew = m_s2 ? 2 * SprW : SprW;
        eh = m_s2 ? 2 * SprH : SprH;
        hit = m_en && !hb && !vb && h >= m_x && h < m_x + ew && v >= m_y && v < m_y + eh;
        dx = m_s2 ? (h - m_x) / 2 : (h - m_x);
        dy = m_s2 ? (v - m_y) / 2 : (v - m_y);
        col = m_flip ? SprW - 1 - dx : dx;
        addr = dy * 64 + col;
        a12 = 12'(addr);
        pix = rom_zero ? 12'h000 : {1'b1, a12[10:0]};
        x.due = cyc + Lat;
        x.rgb_key = (hit && pix != 12'h000) ? pix : rgbv;
        x.rgb_nokey = hit ? pix : rgbv;
        x.tim = {hh, vv, hh[4], vv[0], hb, vb};
        sb.push_back(x);
        if (hit) m_addr = addr;
        // Latch takes effect after this pixel, which still saw the old values.
        if (vb && !m_prev) begin
            m_x = int'(xpos);
            m_y = int'(ypos);
            m_en = enable;
            m_flip = hflip;
            m_s2 = scale2;
        end
        m_prev = vb;
    endtask

    task automatic line(input int v, input int h0, input int h1, input int spot_h,
                        input int spot_val);
        for (int h = h0; h <= h1; h++) step(h, v, 1'b0, 1'b0, (h == spot_h) ? spot_val : -1);
    endtask

    task automatic latch_frame(input int x, input int y, input bit en, input bit fl, input bit s2);
        xpos = 12'(x);
        ypos = 12'(y);
        enable = en;
        hflip = fl;
        scale2 = s2;
        step(0, 600, 1'b1, 1'b1, -1);
        step(1, 600, 1'b1, 1'b1, -1);
        step(2, 0, 1'b1, 1'b0, -1);
    endtask

    initial begin
        // Reset with busy inputs: every output must read zero.
        vin.hcount = 11'h155; vin.vcount = 11'h0AA; vin.hsync = 1'b1; vin.vsync = 1'b1;
        vin.hblnk = 1'b0; vin.vblnk = 1'b1; vin.rgb = 12'hABC;
        repeat (2) @(posedge pclk);
        #1;
        check_eq("rst_bus", 64'({vout0.hcount, vout0.vcount, vout0.hsync, vout0.vsync,
                                 vout0.hblnk, vout0.vblnk, vout0.rgb}), 64'h0);
        check_eq("rst_addr", 64'(addr0), 64'h0);
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        xpos = 12'd100; ypos = 12'd50; enable = 1'b1;
        rst = 1'b1;

        // No sprite before the first latch, even with enable high.
        line(50, 96, 152, -1, -1);

        latch_frame(100, 50, 1'b1, 1'b0, 1'b0);
        line(50, 96, 152, 100, 0);
        line(113, 96, 100, -1, -1);
        line(114, 96, 100, -1, -1);
        step(110, 60, 1'b1, 1'b0, -1);

        latch_frame(100, 50, 1'b1, 1'b1, 1'b0);
        line(51, 96, 152, 100, 64 + 47);

        latch_frame(100, 50, 1'b1, 1'b0, 1'b1);
        line(55, 96, 200, 103, 128 + 1);
        line(177, 96, 100, -1, -1);
        line(178, 96, 100, -1, -1);

        latch_frame(100, 50, 1'b1, 1'b0, 1'b0);
        rom_zero = 1'b1;
        line(60, 96, 152, -1, -1);
        rom_zero = 1'b0;

        // Position change mid-frame must not move the sprite until the next latch.
        line(52, 96, 152, -1, -1);
        xpos = 12'd300;
        line(53, 96, 152, -1, -1);
        line(53, 296, 352, -1, -1);
        latch_frame(300, 50, 1'b1, 1'b0, 1'b0);
        line(54, 296, 352, 300, 4 * 64);
        line(54, 96, 152, -1, -1);

        // Right-edge clipping: no wrap onto low columns.
        latch_frame(4090, 50, 1'b1, 1'b0, 1'b0);
        line(60, 0, 60, -1, -1);
        line(60, 2030, 2047, -1, -1);
        latch_frame(2040, 50, 1'b1, 1'b0, 1'b0);
        line(61, 2030, 2047, 2040, 11 * 64);
        line(61, 0, 50, -1, -1);

        // Mid-line reset clears everything at once.
        latch_frame(100, 50, 1'b1, 1'b0, 1'b0);
        line(62, 96, 120, -1, -1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_bus", 64'({vout0.hcount, vout0.vcount, vout0.hsync, vout0.vsync,
                                    vout0.hblnk, vout0.vblnk, vout0.rgb}), 64'h0);
        check_eq("midrst_rgb_nokey", 64'(vout1.rgb), 64'h0);
        check_eq("midrst_addr", 64'(addr0), 64'h0);
        sb.delete();
        m_x = 0; m_y = 0; m_en = 0; m_flip = 0; m_s2 = 0; m_prev = 0; m_addr = 0;
        spot_pend = -1;
        vin.hblnk = 1'b1; vin.vblnk = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b1;
        line(62, 96, 152, -1, -1);
        latch_frame(100, 50, 1'b1, 1'b0, 1'b0);
        line(63, 96, 152, 100, 13 * 64);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge pclk);
        #1;
        check_eq("drain", 64'(sb.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
